// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Merges two writeback sources onto one registered register-file write port.
//   The pipeline source (p_*) cannot be back-pressured. The multi-cycle source
//   (m_*) is buffered in a 2-entry FIFO. The FIFO head is given the port when
//   the pipeline is idle, or unconditionally once it has been starved for
//   STARVE_LIMIT consecutive cycles. In that case stall_req asks the pipeline to
//   hold off.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   p_valid/p_addr/p_data/p_pc  pipeline writeback request
//   m_valid/m_addr/m_data/m_pc  multi-cycle writeback request
//   m_ready                  FIFO has a free slot this cycle
//   we/wa/wd/wpc             registered write port (enable, addr, data, PC)
//   stall_req                head has been starved long enough; pipeline must idle
//   pend_mask                one bit per register targeted by a queued entry
//   err                      sticky: a pipeline request arrived while stalled
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic [31:0] p_pc,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  input  logic [31:0] m_pc,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic [31:0] wpc,
  output logic        stall_req,
  output logic [31:0] pend_mask,
  output logic        err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // FIFO storage: slot 0 is always the head; a dequeue shifts slot 1 down.
  logic [1:0]  count_q, count_d;
  logic [4:0]  ent_addr_q [2];
  logic [4:0]  ent_addr_d [2];
  logic [31:0] ent_data_q [2];
  logic [31:0] ent_data_d [2];
  logic [31:0] ent_pc_q   [2];
  logic [31:0] ent_pc_d   [2];

  logic [3:0]  starve_q, starve_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] wpc_q, wpc_d;

  logic non_empty;
  logic grant_m;
  logic grant_p;
  logic enq;
  logic wr_slot;

  assign non_empty = (count_q != 2'd0);
  assign m_ready   = (count_q != 2'd2);
  assign stall_req = (starve_q >= LIMIT);
  assign enq       = m_valid && m_ready;

  // Head wins when forced by starvation or when the pipeline is idle.
  assign grant_m = non_empty && (stall_req || !p_valid);
  assign grant_p = p_valid && !grant_m;

  // Enqueue slot: when the head leaves in the same cycle the new entry lands
  // in slot 0 (the FIFO held exactly one entry, since a full FIFO blocks enq).
  assign wr_slot = !grant_m && (count_q == 2'd1);

  always_comb begin
    count_d    = count_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    ent_pc_d   = ent_pc_q;
    starve_d   = starve_q;
    err_d      = err_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    wpc_d      = wpc_q;

    // Write port: address 0 is consumed but never written.
    if (grant_m) begin
      if (ent_addr_q[0] != 5'd0) begin
        we_d  = 1'b1;
        wa_d  = ent_addr_q[0];
        wd_d  = ent_data_q[0];
        wpc_d = ent_pc_q[0];
      end
    end else if (grant_p) begin
      if (p_addr != 5'd0) begin
        we_d  = 1'b1;
        wa_d  = p_addr;
        wd_d  = p_data;
        wpc_d = p_pc;
      end
    end

    // A pipeline request alongside a granted head can only happen under
    // stall; that request is lost, so flag it.
    if (p_valid && grant_m) begin
      err_d = 1'b1;
    end

    if (grant_m) begin
      ent_addr_d[0] = ent_addr_q[1];
      ent_data_d[0] = ent_data_q[1];
      ent_pc_d[0]   = ent_pc_q[1];
      count_d       = count_q - 2'd1;
    end
    if (enq) begin
      ent_addr_d[wr_slot] = m_addr;
      ent_data_d[wr_slot] = m_data;
      ent_pc_d[wr_slot]   = m_pc;
      count_d             = count_d + 2'd1;
    end

    if (!non_empty || grant_m) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      starve_q <= 4'd0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= 5'd0;
      wd_q     <= 32'd0;
      wpc_q    <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        ent_addr_q[i] <= 5'd0;
        ent_data_q[i] <= 32'd0;
        ent_pc_q[i]   <= 32'd0;
      end
    end else begin
      count_q    <= count_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      wpc_q      <= wpc_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      ent_pc_q   <= ent_pc_d;
    end
  end

  // One bit per register: set if either valid entry targets it (r0 excluded).
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_mask[gi] = 1'b0;
      end else begin : g_reg
        assign pend_mask[gi] =
          ((count_q != 2'd0) && (ent_addr_q[0] == 5'(gi))) ||
          ((count_q == 2'd2) && (ent_addr_q[1] == 5'(gi)));
      end
    end
  endgenerate

  assign we  = we_q;
  assign wa  = wa_q;
  assign wd  = wd_q;
  assign wpc = wpc_q;
  assign err = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_valid = 1'b0;
  logic [4:0]  p_addr = '0;
  logic [31:0] p_data = '0;
  logic [31:0] p_pc = '0;
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pc = '0;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] wpc;
  logic        stall_req;
  logic [31:0] pend_mask;
  logic        err;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc),
    .stall_req(stall_req), .pend_mask(pend_mask), .err(err)
  );

  always #5 clk = ~clk;

  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  // Reference model: a queue for the FIFO, an integer for starvation count.
  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_err = 0;
  bit          m_we = 0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_wpc = '0;
  bit          m_was_rst = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].a != 0) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit r, input bit pv, input logic [4:0] pa,
                     input logic [31:0] pd, input logic [31:0] ppc,
                     input bit mv, input logic [4:0] ma,
                     input logic [31:0] md, input logic [31:0] mpc);
    bit   ne, stall, ready, head_wins;
    ent_t e;
    rst = r; p_valid = pv; p_addr = pa; p_data = pd; p_pc = ppc;
    m_valid = mv; m_addr = ma; m_data = md; m_pc = mpc;

    ne    = (mq.size() > 0);
    stall = (m_starve >= LIMIT);
    ready = (mq.size() < 2);
    if (r) begin
      mq.delete();
      m_starve = 0; m_err = 0; m_we = 0;
      m_wa = '0; m_wd = '0; m_wpc = '0;
      m_was_rst = 1;
    end else begin
      m_was_rst = 0;
      head_wins = ne && (stall || !pv);
      m_we = 0;
      if (head_wins) begin
        e = mq.pop_front();
        if (e.a != 0) begin m_we = 1; m_wa = e.a; m_wd = e.d; m_wpc = e.pc; end
        if (pv) m_err = 1;
      end else if (pv && pa != 0) begin
        m_we = 1; m_wa = pa; m_wd = pd; m_wpc = ppc;
      end
      if (mv && ready) begin
        e.a = ma; e.d = md; e.pc = mpc;
        mq.push_back(e);
      end
      if (head_wins || !ne) m_starve = 0;
      else if (m_starve < 15) m_starve++;
    end

    @(posedge clk);
    #1;
    chk("m_ready", 32'(m_ready), 32'(mq.size() < 2));
    chk("stall_req", 32'(stall_req), 32'(m_starve >= LIMIT));
    chk("pend_mask", pend_mask, model_pend());
    chk("err", 32'(err), 32'(m_err));
    chk("we", 32'(we), 32'(m_we));
    if (m_we || m_was_rst) begin
      chk("wa", 32'(wa), 32'(m_wa));
      chk("wd", wd, m_wd);
      chk("wpc", wpc, m_wpc);
    end
    if (we) $display("t=%0t write wa=%0d wd=0x%08h wpc=0x%08h", $time, wa, wd, wpc);
  endtask

  task automatic reset_cyc();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Two enqueues with the pipeline busy: FIFO holds [3,4], starve count 1.
  task automatic fill_two();
    cyc(0, 1, 5'd1, 32'h11, 32'h100, 1, 5'd3, 32'h33, 32'h300);
    cyc(0, 1, 5'd2, 32'h22, 32'h200, 1, 5'd4, 32'h44, 32'h400);
  endtask

  initial begin
    // Reset state
    reset_cyc();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_m_ready", 32'(m_ready), 32'd1);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_pend", pend_mask, 32'd0);

    // Pipeline write, one-cycle latency
    cyc(0, 1, 5'd5, 32'h1234, 32'h00400010, 0, 0, 0, 0);
    chk("p_we", 32'(we), 32'd1);
    chk("p_wa", 32'(wa), 32'd5);
    chk("p_wd", wd, 32'h00001234);
    chk("p_wpc", wpc, 32'h00400010);

    // m request: pending after one cycle, written after two
    cyc(0, 0, 0, 0, 0, 1, 5'd8, 32'hDEAD, 32'h500);
    chk("m_pend1", pend_mask, 32'h100);
    chk("m_we1", 32'(we), 32'd0);
    idle();
    chk("m_we2", 32'(we), 32'd1);
    chk("m_wa2", 32'(wa), 32'd8);
    chk("m_wd2", wd, 32'h0000DEAD);
    chk("m_pend2", pend_mask, 32'd0);

    // Starvation then release with p_valid low
    reset_cyc();
    fill_two();
    chk("full_ready", 32'(m_ready), 32'd0);
    chk("full_pend", pend_mask, 32'h18);
    cyc(0, 1, 5'd6, 32'h66, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
    chk("stall_before", 32'(stall_req), 32'd0);
    cyc(0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    chk("stall_rise", 32'(stall_req), 32'd1);
    idle();
    chk("rel_wa3", 32'(wa), 32'd3);
    chk("rel_we3", 32'(we), 32'd1);
    chk("rel_stall", 32'(stall_req), 32'd0);
    idle();
    chk("rel_wa4", 32'(wa), 32'd4);
    chk("rel_err", 32'(err), 32'd0);

    // Pipeline request during stall is dropped and flagged
    reset_cyc();
    fill_two();
    repeat (3) cyc(0, 1, 5'd10, 32'hAA, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd9, 32'h99, 32'h990, 0, 0, 0, 0);
    chk("drop_wa", 32'(wa), 32'd3);
    chk("drop_wd", wd, 32'h33);
    chk("drop_err", 32'(err), 32'd1);
    idle();
    idle();
    chk("err_sticky", 32'(err), 32'd1);
    reset_cyc();
    chk("err_clr", 32'(err), 32'd0);

    // Address 0 consumed silently
    cyc(0, 0, 0, 0, 0, 1, 5'd0, 32'hBEEF, 32'h600);
    chk("z_pend", pend_mask, 32'd0);
    idle();
    chk("z_we", 32'(we), 32'd0);
    chk("z_ready", 32'(m_ready), 32'd1);

    // Reset mid-operation with two entries and starve count 3
    fill_two();
    cyc(0, 1, 5'd11, 32'hB, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd12, 32'hC, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", 32'(stall_req), 32'd0);
    cyc(1, 1, 5'd13, 32'hD, 0, 1, 5'd14, 32'hE, 0);
    chk("mid_rst_ready", 32'(m_ready), 32'd1);
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    chk("mid_rst_pend", pend_mask, 32'd0);
    chk("mid_rst_we", 32'(we), 32'd0);
    repeat (3) idle();
    chk("no_stale_we", 32'(we), 32'd0);

    // Randomized traffic, with bursts of a busy pipeline to provoke starvation
    for (int n = 0; n < 600; n++) begin
      bit r, pv, mv;
      int burst;
      burst = ((n / 40) % 2 == 1);
      r  = ($urandom_range(0, 79) == 0);
      pv = burst ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
      mv = ($urandom_range(0, 1) == 1);
      cyc(r, pv, 5'($urandom), $urandom, $urandom, mv, 5'($urandom_range(0, 7)), $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles of the FIFO head before stall_req asserts (legal range 1..15).
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port p_valid  in  1  pipeline writeback request; cannot be back-pressured.
REQ-005 SHALL have ports p_addr  in  5, p_data  in  32, p_pc  in  32  pipeline destination register, data, instruction PC.
REQ-006 SHALL have port m_valid  in  1  multi-cycle unit (mul/div) writeback request.
REQ-007 SHALL have port m_ready  out  1  FIFO can accept an m request this cycle.
REQ-008 SHALL have ports m_addr  in  5, m_data  in  32, m_pc  in  32  multi-cycle destination, data, PC.
REQ-009 SHALL have ports we  out  1, wa  out  5, wd  out  32, wpc  out  32  registered register-file write port (write enable, address, data, PC).
REQ-010 SHALL have port stall_req  out  1  asks the pipeline to hold p_valid low next cycle.
REQ-011 SHALL have port pend_mask  out  32  bit k set when any FIFO entry targets register k.
REQ-012 SHALL have port err  out  1  sticky protocol-violation flag.

Function
REQ-013 SHALL hold m requests in a 2-entry FIFO; enqueue when m_valid && m_ready; m_ready = FIFO not full (dequeue in the same cycle not considered).
REQ-014 SHALL arbitrate each cycle: stall_req=1 and FIFO non-empty -> FIFO head granted; else p_valid -> p granted; else FIFO non-empty -> head granted; else none.
REQ-015 SHALL load the granted request into we/wa/wd/wpc at the next rising edge (p latency 1 cycle; m latency >= 2 cycles from enqueue); we=0 when nothing granted, wa/wd/wpc then hold prior values.
REQ-016 SHALL consume a granted request with address 0 (dequeue/accept normally) but drive we=0 for it.
REQ-017 SHALL dequeue the FIFO head in the cycle it is granted; enqueue and dequeue in the same cycle SHALL both take effect, order preserved.
REQ-018 SHALL count cycles where FIFO is non-empty and head not granted in a 4-bit saturating counter; counter clears on any dequeue or when FIFO is empty.
REQ-019 SHALL drive stall_req = (counter >= STARVE_LIMIT), combinationally from the counter.
REQ-020 SHALL, when p_valid=1 while stall_req=1 and FIFO head granted, drop the p request (never written) and set err=1 until reset.
REQ-021 SHALL compute pend_mask combinationally as OR of one-hot(addr) over valid FIFO entries, excluding address 0.
REQ-022 SHALL ignore m_valid when m_ready=0 (no enqueue, no error).

Reset
REQ-023 SHALL on rst=1 at a rising edge: empty FIFO, counter=0, err=0, we=0, wa=0, wd=0, wpc=0; then m_ready=1, stall_req=0, pend_mask=0.
REQ-024 SHALL give rst priority over any simultaneous request; requests in the reset cycle are discarded, including FIFO contents mid-operation.

Verification
REQ-025 p_valid=1, p_addr=5, p_data=0x1234, p_pc=0x00400010 with empty FIFO -> next cycle we=1, wa=5, wd=0x00001234, wpc=0x00400010.
REQ-026 m enqueue addr=8 data=0xDEAD at cycle 0, p_valid=0 thereafter -> pend_mask=0x100 at cycle 1, we=1/wa=8/wd=0x0000DEAD at cycle 2, pend_mask=0 at cycle 2.
REQ-027 Two m enqueues (addr 3, 4) with p_valid held 1 -> m_ready=0 after second; stall_req rises after 4 denied cycles; next cycle with p_valid=0 writes addr 3, counter clears, then addr 4 follows.
REQ-028 p_valid=1 while stall_req=1 -> FIFO head written, p request absent from write port, err=1 and stays 1 until rst.
REQ-029 m enqueue addr=0 -> no pend_mask bit, request consumed, we stays 0.
REQ-030 rst asserted with two FIFO entries and counter=3 -> next cycle m_ready=1, stall_req=0, pend_mask=0, we=0, no stale write ever issued.
